// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory-access stage: opcode match patterns,
// load/store width codes and the access FSM state type.
package memory_access_pkg;

  // Wildcard opcode patterns, matched with ==? against the full instruction
  localparam logic [31:0] I_ALL_LOADS = 32'b????_????_????_????_????_????_?000_0011;
  localparam logic [31:0] S_ALL       = 32'b????_????_????_????_????_????_?010_0011;

  // Load widths (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store widths (funct3)
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    MA_IDLE,
    MA_REQ,
    MA_WAIT
  } ma_state_t;

endpackage

// File: rtl/memory_access_lsu_align.sv
// Combinational lane logic for the memory-access stage: byte enables and
// replicated store data on the request side, alignment check, and lane
// selection plus sign/zero extension on the load-return side.
module lsu_align
  import memory_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Access width is funct3[1:0] for both loads and stores; width 3 is unsupported
  // on this 32-bit port and is dropped as misaligned.
  always_comb begin
    be         = 4'b0000;
    wdata      = rs2;
    misaligned = 1'b0;
    case (funct3[1:0])
      F3_SB[1:0]: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{rs2[7:0]}};
      end
      F3_SH[1:0]: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{rs2[15:0]}};
        misaligned = addr_lo[0];
      end
      F3_SW[1:0]: begin
        be         = 4'b1111;
        wdata      = rs2;
        misaligned = |addr_lo;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // Pick the addressed byte / halfword from the returned word
  always_comb begin
    lane_b = rdata[7:0];
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane according to the load flavour
  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  load_data = {24'h0, lane_b};
      F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  load_data = {16'h0, lane_h};
      F3_LW:   load_data = rdata;
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage. Non-memory instructions pass through in one
// cycle; loads and stores run a req/gnt/rvalid handshake on the data port while
// stalling execute, with a watchdog that abandons an access that never finishes.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  sel_rd_i,
  output logic        stall_o,
  output logic [31:0] instr_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  sel_rd_o,
  output logic        wb_en_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  // Last counter value at which the access may still complete
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  ma_state_t        state;
  logic [CNT_W-1:0] wait_cnt;

  // Access captured in IDLE and held for the duration of the transaction
  logic [31:0] acc_instr_p1;
  logic [31:0] acc_addr_p1;
  logic [31:0] acc_wdata_p1;
  logic [3:0]  acc_be_p1;
  logic        acc_we_p1;
  logic [2:0]  acc_funct3_p1;
  logic [4:0]  acc_rd_p1;

  logic        in_idle;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        timed_out;

  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load_data;
  logic        al_misaligned;

  assign in_idle   = (state == MA_IDLE);
  assign is_load   = (instr_i ==? I_ALL_LOADS);
  assign is_store  = (instr_i ==? S_ALL);
  assign is_mem    = is_load | is_store;
  assign timed_out = (wait_cnt >= CNT_LAST);

  assign stall_o      = !in_idle;
  assign dmem_req_o   = (state == MA_REQ);
  assign dmem_we_o    = acc_we_p1;
  assign dmem_addr_o  = {acc_addr_p1[31:2], 2'b00};
  assign dmem_be_o    = acc_be_p1;
  assign dmem_wdata_o = acc_wdata_p1;

  // The lane logic is shared: in IDLE it sees the incoming instruction (request
  // side); while an access is open it sees the captured one (load-return side).
  assign al_funct3  = in_idle ? instr_i[14:12]     : acc_funct3_p1;
  assign al_addr_lo = in_idle ? alu_result_i[1:0] : acc_addr_p1[1:0];

  lsu_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .rs2        (rs2_i),
    .rdata      (dmem_rdata_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .misaligned (al_misaligned),
    .load_data  (al_load_data)
  );

  // FSM, watchdog counter, captured access and write-back outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= MA_IDLE;
      wait_cnt      <= '0;
      acc_instr_p1  <= '0;
      acc_addr_p1   <= '0;
      acc_wdata_p1  <= '0;
      acc_be_p1     <= '0;
      acc_we_p1     <= 1'b0;
      acc_funct3_p1 <= '0;
      acc_rd_p1     <= '0;
      instr_o       <= '0;
      wb_data_o     <= '0;
      sel_rd_o      <= '0;
      wb_en_o       <= 1'b0;
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
    end else begin
      // Write-back outputs are bubbles unless something retires this edge
      instr_o    <= '0;
      wb_data_o  <= '0;
      sel_rd_o   <= '0;
      wb_en_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;

      case (state)
        MA_IDLE: begin
          if (is_mem) begin
            if (al_misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              acc_instr_p1  <= instr_i;
              acc_addr_p1   <= alu_result_i;
              acc_wdata_p1  <= al_wdata;
              acc_be_p1     <= al_be;
              acc_we_p1     <= is_store;
              acc_funct3_p1 <= instr_i[14:12];
              acc_rd_p1     <= sel_rd_i;
              wait_cnt      <= '0;
              state         <= MA_REQ;
            end
          end else begin
            instr_o   <= instr_i;
            wb_data_o <= alu_result_i;
            sel_rd_o  <= sel_rd_i;
            wb_en_o   <= (sel_rd_i != 5'd0);
          end
        end

        MA_REQ: begin
          // A grant always wins over the watchdog so the memory never holds
          // an accepted request the stage has forgotten about.
          if (dmem_gnt_i) begin
            if (acc_we_p1) begin
              instr_o <= acc_instr_p1;
              state   <= MA_IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
              state    <= MA_WAIT;
            end
          end else if (timed_out) begin
            bus_err_o <= 1'b1;
            state     <= MA_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        MA_WAIT: begin
          if (dmem_rvalid_i) begin
            instr_o   <= acc_instr_p1;
            wb_data_o <= al_load_data;
            sel_rd_o  <= acc_rd_p1;
            wb_en_o   <= (acc_rd_p1 != 5'd0);
            state     <= MA_IDLE;
          end else if (timed_out) begin
            bus_err_o <= 1'b1;
            state     <= MA_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state <= MA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a table of instructions with hand-computed
// pinned results, a transaction-level model that schedules the expected outputs
// of every cycle, and a memory responder with per-access grant/return delays.
module tb_memory_access;

  localparam int T    = 4;
  localparam int NEXP = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i, alu_result_i, rs2_i;
  logic [4:0]  sel_rd_i;
  logic        stall_o;
  logic [31:0] instr_o, wb_data_o;
  logic [4:0]  sel_rd_o;
  logic        wb_en_o, misalign_o, bus_err_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  memory_access #(.WAIT_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .alu_result_i(alu_result_i),
    .rs2_i(rs2_i), .sel_rd_i(sel_rd_i), .stall_o(stall_o), .instr_o(instr_o),
    .wb_data_o(wb_data_o), .sel_rd_o(sel_rd_o), .wb_en_o(wb_en_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, alu, rs2, rdata;
    logic [4:0]  rd;
    int          g, r;      // req cycles before gnt; cycles from gnt to rvalid (0 = never)
    int          pk;        // pinned check: 0 none,1 data,2 misalign,3 bus error,4 store retire
    logic [31:0] pv;
    int          ps;        // expected stall cycles, -1 = unchecked
  } op_t;

  typedef struct {
    logic        stall, req, we, wb_en, mis, berr, dv;
    logic [31:0] addr, wdata, instr, data;
    logic [3:0]  be;
    logic [4:0]  rd;
  } exp_t;

  exp_t sched [NEXP];
  exp_t cmp_e;
  op_t  ops[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  // memory responder state
  int          cur_g = 0, cur_r = 0, req_cnt = 0, rv_cd = 0;
  logic [31:0] cur_rdata = '0, pend_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, expv);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc, input logic [4:0] rd);
    return {17'h0, f3, rd, opc};
  endfunction

  task automatic add(input logic [31:0] instr, input logic [4:0] rd, input logic [31:0] alu,
                     input logic [31:0] rs2, input logic [31:0] rdata, input int g, input int r,
                     input int pk, input logic [31:0] pv, input int ps);
    op_t o;
    o.instr = instr; o.rd = rd; o.alu = alu; o.rs2 = rs2; o.rdata = rdata;
    o.g = g; o.r = r; o.pk = pk; o.pv = pv; o.ps = ps;
    ops.push_back(o);
  endtask

  // Model: from the instruction and the memory's delays, decide what each
  // cycle after acceptance edge k must look like.
  task automatic model_issue(input op_t op, input int k);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] sh, ld, wd;
    logic [3:0]  be;
    logic        is_ld;
    int          nb, done, dur, nreq;
    opc = op.instr[6:0];
    f3  = op.instr[14:12];
    a   = op.alu[1:0];
    if (k + T + 1 >= NEXP) return;
    if (opc != 7'b0000011 && opc != 7'b0100011) begin
      sched[k].instr = op.instr; sched[k].data = op.alu; sched[k].rd = op.rd;
      sched[k].wb_en = (op.rd != 0); sched[k].dv = 1'b1;
      return;
    end
    is_ld = (opc == 7'b0000011);
    nb    = 1 << f3[1:0];
    if ((int'(op.alu[2:0]) % nb) != 0) begin
      sched[k].mis = 1'b1;
      return;
    end
    be = 4'(((1 << nb) - 1) << a);
    wd = (nb == 1) ? {4{op.rs2[7:0]}} : (nb == 2) ? {2{op.rs2[15:0]}} : op.rs2;
    sh = op.rdata >> (8 * a);
    case (f3)
      3'd0:    ld = {{24{sh[7]}}, sh[7:0]};
      3'd4:    ld = {24'h0, sh[7:0]};
      3'd1:    ld = {{16{sh[15]}}, sh[15:0]};
      3'd5:    ld = {16'h0, sh[15:0]};
      default: ld = op.rdata;
    endcase
    done = is_ld ? ((op.r > 0) ? op.g + op.r + 1 : 1 << 20) : op.g + 1;
    dur  = (done <= T) ? done : T;
    nreq = (op.g + 1 < dur) ? op.g + 1 : dur;
    for (int j = 0; j < dur; j++) begin
      sched[k+j].stall = 1'b1;
      if (j < nreq) begin
        sched[k+j].req = 1'b1; sched[k+j].we = !is_ld;
        sched[k+j].addr = {op.alu[31:2], 2'b00}; sched[k+j].be = be; sched[k+j].wdata = wd;
      end
    end
    if (done <= T) begin
      sched[k+dur].instr = op.instr;
      if (is_ld) begin
        sched[k+dur].dv = 1'b1; sched[k+dur].data = ld; sched[k+dur].rd = op.rd;
        sched[k+dur].wb_en = (op.rd != 0);
      end
    end else begin
      sched[k+dur].berr = 1'b1;
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && rst_n && cyc < NEXP) begin
      cmp_e = sched[cyc];
      chk("stall", 32'(stall_o), 32'(cmp_e.stall));
      chk("req", 32'(dmem_req_o), 32'(cmp_e.req));
      if (cmp_e.req) begin
        chk("we", 32'(dmem_we_o), 32'(cmp_e.we));
        chk("addr", dmem_addr_o, cmp_e.addr);
        chk("be", 32'(dmem_be_o), 32'(cmp_e.be));
        chk("wdata", dmem_wdata_o, cmp_e.wdata);
      end
      chk("instr", instr_o, cmp_e.instr);
      chk("wb_en", 32'(wb_en_o), 32'(cmp_e.wb_en));
      if (cmp_e.dv) begin
        chk("wb_data", wb_data_o, cmp_e.data);
        chk("sel_rd", 32'(sel_rd_o), 32'(cmp_e.rd));
      end
      chk("misalign", 32'(misalign_o), 32'(cmp_e.mis));
      chk("bus_err", 32'(bus_err_o), 32'(cmp_e.berr));
    end
  end

  // Memory responder: grant after cur_g idle request cycles, return data cur_r cycles later
  always @(negedge clk) begin
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    if (!rst_n) begin
      req_cnt = 0; rv_cd = 0;
    end else if (rv_cd > 0) begin
      rv_cd--;
      if (rv_cd == 0) begin
        dmem_rvalid_i = 1'b1; dmem_rdata_i = pend_rdata;
      end
    end else if (dmem_req_o) begin
      if (req_cnt == cur_g) begin
        dmem_gnt_i = 1'b1; req_cnt = 0;
        if (cur_r > 0) begin
          rv_cd = cur_r; pend_rdata = cur_rdata;
        end
      end else begin
        req_cnt++;
      end
    end else begin
      req_cnt = 0;
    end
  end

  task automatic drive_idle();
    instr_i = '0; alu_result_i = '0; rs2_i = '0; sel_rd_i = '0;
  endtask

  task automatic drive(input op_t op);
    instr_i = op.instr; alu_result_i = op.alu; rs2_i = op.rs2; sel_rd_i = op.rd;
    cur_g = op.g; cur_r = op.r; cur_rdata = op.rdata;
    model_issue(op, cyc + 1);
  endtask

  task automatic wait_idle(output int waited);
    waited = 0;
    while (stall_o) begin
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        $display("FAIL stall_timeout cyc=%0d got stall=1 want 0", cyc);
        $fatal(1, "stall never released");
      end
    end
  endtask

  task automatic pin(input op_t op, input int waited);
    if (op.ps >= 0) chk("stall_cycles", 32'(waited), 32'(op.ps));
    case (op.pk)
      1: begin
        chk("pin_data", wb_data_o, op.pv);
        chk("pin_en", 32'(wb_en_o), 32'(op.rd != 0));
      end
      2: begin
        chk("pin_mis", 32'(misalign_o), 32'd1);
        chk("pin_mis_noreq", 32'(dmem_req_o), 32'd0);
      end
      3: chk("pin_berr", 32'(bus_err_o), 32'd1);
      4: begin
        chk("pin_st_instr", instr_o, op.instr);
        chk("pin_st_en", 32'(wb_en_o), 32'd0);
      end
      default: ;
    endcase
  endtask

  initial begin
    int w;
    logic [31:0] ADD, SB, SH, SW, LB, LH, LW, LBU, LHU;
    ADD = mk(3'd0, 7'b0110011, 5'd0);
    SB  = mk(3'd0, 7'b0100011, 5'd0);
    SH  = mk(3'd1, 7'b0100011, 5'd0);
    SW  = mk(3'd2, 7'b0100011, 5'd0);
    LB  = mk(3'd0, 7'b0000011, 5'd0);
    LH  = mk(3'd1, 7'b0000011, 5'd0);
    LW  = mk(3'd2, 7'b0000011, 5'd0);
    LBU = mk(3'd4, 7'b0000011, 5'd0);
    LHU = mk(3'd5, 7'b0000011, 5'd0);
    for (int i = 0; i < NEXP; i++) sched[i] = '{default: '0};

    //  instr       rd     alu            rs2            rdata          g   r  pk  pin value      stall
    add(ADD|(5<<7),  5'd5,  32'h1234,      32'h0,         32'h0,         0,  0, 1,  32'h1234,     0);
    add(32'h0,       5'd0,  32'h0,         32'h0,         32'h0,         0,  0, 1,  32'h0,        0);
    add(ADD,         5'd0,  32'h55,        32'h0,         32'h0,         0,  0, 1,  32'h55,       0);
    add(SW,          5'd0,  32'h100,       32'hDEADBEEF,  32'h0,         2,  0, 4,  32'h0,        3);
    add(LB,          5'd7,  32'h103,       32'h0,         32'h80123456,  0,  1, 1,  32'hFFFFFF80, 2);
    add(LBU,         5'd8,  32'h103,       32'h0,         32'h80123456,  0,  1, 1,  32'h00000080, 2);
    add(LH,          5'd9,  32'h101,       32'h0,         32'h0,         0,  0, 2,  32'h0,        0);
    add(LH,          5'd10, 32'h102,       32'h0,         32'h80017FFF,  1,  1, 1,  32'hFFFF8001, 3);
    add(LHU,         5'd11, 32'h102,       32'h0,         32'h80017FFF,  0,  2, 1,  32'h00008001, 3);
    add(LW,          5'd0,  32'h200,       32'h0,         32'hCAFEF00D,  0,  1, 1,  32'hCAFEF00D, 2);
    add(SB,          5'd0,  32'h101,       32'h11223344,  32'h0,         0,  0, 4,  32'h0,        1);
    add(SH,          5'd0,  32'h102,       32'hAABBCCDD,  32'h0,         1,  0, 4,  32'h0,        2);
    add(SW,          5'd0,  32'h102,       32'h1,         32'h0,         0,  0, 2,  32'h0,        0);
    add(LW,          5'd12, 32'h300,       32'h0,         32'h0,         0,  0, 3,  32'h0,        4);
    add(SW,          5'd0,  32'h104,       32'h1,         32'h0,         99, 0, 3,  32'h0,        4);
    add(LW,          5'd13, 32'h304,       32'h0,         32'h12345678,  1,  5, 3,  32'h0,        4);
    add(ADD,         5'd1,  32'hA5A5,      32'h0,         32'h0,         0,  0, 1,  32'hA5A5,     0);
    add(ADD,         5'd31, 32'hFFFFFFFF,  32'h0,         32'h0,         0,  0, 1,  32'hFFFFFFFF, 0);
    add(32'h0,       5'd0,  32'h0,         32'h0,         32'h0,         0,  0, 0,  32'h0,        -1);
    add(32'h0,       5'd0,  32'h0,         32'h0,         32'h0,         0,  0, 0,  32'h0,        -1);

    // Reset state
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_wb_en", 32'(wb_en_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    for (int i = 0; i < ops.size(); i++) begin
      wait_idle(w);
      if (i > 0) pin(ops[i-1], w);
      drive(ops[i]);
      @(negedge clk);
      drive_idle();
    end
    wait_idle(w);
    pin(ops[ops.size()-1], w);

    // Reset while a load sits in WAIT
    begin
      op_t o;
      o.instr = LW; o.rd = 5'd14; o.alu = 32'h400; o.rs2 = '0; o.rdata = '0;
      o.g = 0; o.r = 0; o.pk = 0; o.pv = '0; o.ps = -1;
      drive(o);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      chk("pre_rst_stall", 32'(stall_o), 32'd1);
      chk("pre_rst_be", 32'(dmem_be_o), 32'hF);
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("mid_rst_stall", 32'(stall_o), 32'd0);
      chk("mid_rst_req", 32'(dmem_req_o), 32'd0);
      chk("mid_rst_addr", dmem_addr_o, 32'd0);
      chk("mid_rst_be", 32'(dmem_be_o), 32'd0);
      chk("mid_rst_instr", instr_o, 32'd0);
      chk("mid_rst_wb_data", wb_data_o, 32'd0);
      for (int i = cyc; i < NEXP; i++) sched[i] = '{default: '0};
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      o.instr = ADD | (6 << 7); o.rd = 5'd6; o.alu = 32'h77; o.pk = 1; o.pv = 32'h77; o.ps = 0;
      wait_idle(w);
      drive(o);
      @(negedge clk);
      drive_idle();
      wait_idle(w);
      pin(o, w);
      repeat (3) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
